mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
- Multicycle main control FSM for the MIPS-subset core.
- Sequences fetch, decode, execute, memory and writeback over several clocks, and drives every datapath strobe.
- Generates the 4-bit ALUOp consumed by the ALU control decoder.
- Sits between the instruction register (opcode) and the datapath muxes, register file, PC and memory port.

Parameters:
- TRAP_ON_ILLEGAL, 1, 1: an illegal opcode enters S_TRAP and halts. 0: an illegal opcode retires as a NOP and returns to S_FETCH.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- opcode  in  6  IR[31:26]; valid from S_DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current read or write this cycle
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- ir_write  out  1  load IR
- pc_write  out  1  load PC
- pc_source  out  2  PC mux: 00 = ALU, 01 = ALUOut (branch target), 10 = jump target
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = rs
- alu_src_b  out  2  ALU B select: 00 = rt, 01 = const 4, 10 = immediate, 11 = immediate<<2
- imm_zext  out  1  immediate is zero-extended (andi, ori, xori), else sign-extended
- ALUOp  out  4  operation class sent to the ALU control decoder
- reg_write  out  1  register file write
- reg_dst  out  1  write register select: 1 = rd, 0 = rt
- mem_to_reg  out  1  write data select: 1 = MDR, 0 = ALUOut
- instr_done  out  1  one-cycle pulse when an instruction retires
- illegal  out  1  sticky illegal-opcode flag

Behaviour:
- Reset: one clock, reset is synchronous and active-high. rst=1 at a rising edge sets state to S_FETCH and clears illegal.
- While rst=1, all strobes, instr_done and illegal are 0, ALUOp=0010 and the other selects are 0.
- Reset mid-instruction aborts it with no write strobe asserted.
- Outputs are Moore-decoded from state and opcode. Exceptions: pc_write and ir_write in S_FETCH are gated by mem_ready; pc_write in S_BRANCH is gated by zero.
- Opcode map and execute-phase ALUOp:
  - R-type 000000: ALUOp 0000
  - j 000010: no ALU operation
  - beq 000100: ALUOp 0100
  - bne 000101: ALUOp 0101
  - addi 001000: ALUOp 1000
  - slti 001010: ALUOp 1010
  - sltiu 001011: ALUOp 1011
  - andi 001100: ALUOp 1100
  - ori 001101: ALUOp 1101
  - xori 001110: ALUOp 1110
  - lw 100011, sw 101011: ALUOp 0010 (add)
  - For I-type and branch instructions, ALUOp equals opcode[3:0].
  - Address and PC arithmetic always uses ALUOp 0010 (add).
- S_FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, pc_source=00, ALUOp=0010. Holds until mem_ready=1; that cycle ir_write=1 and pc_write=1, then go to S_DECODE.
- S_DECODE: alu_src_a=0, alu_src_b=11, ALUOp=0010 (branch target into ALUOut). Next state by opcode:
  - lw/sw -> S_MEMADR
  - R-type -> S_REXEC
  - I-type ALU -> S_IEXEC
  - beq/bne -> S_BRANCH
  - j -> S_JUMP
  - anything else -> S_TRAP (TRAP_ON_ILLEGAL=1) or S_FETCH with instr_done=1 (TRAP_ON_ILLEGAL=0)
- S_MEMADR: alu_src_a=1, alu_src_b=10, ALUOp=0010. Next is S_MEMRD for lw, S_MEMWR for sw.
- S_MEMRD: mem_read=1, iord=1; waits for mem_ready, then S_MEMWB.
- S_MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1, then S_FETCH.
- S_MEMWR: mem_write=1, iord=1; waits for mem_ready. In the mem_ready cycle instr_done=1, then S_FETCH.
- S_REXEC: alu_src_a=1, alu_src_b=00, ALUOp=0000, then S_RWB.
- S_RWB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1, then S_FETCH.
- S_IEXEC: alu_src_a=1, alu_src_b=10, ALUOp=opcode[3:0], imm_zext per the opcode map, then S_IWB.
- S_IWB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1, then S_FETCH.
- S_BRANCH: alu_src_a=1, alu_src_b=00, ALUOp=opcode[3:0], pc_source=01.
  - pc_write=1 iff (beq and zero=1) or (bne and zero=0).
  - instr_done=1, then S_FETCH.
- S_JUMP: pc_source=10, pc_write=1, instr_done=1, then S_FETCH.
- S_TRAP: all strobes 0, illegal=1. Only rst exits this state.
- Latency in cycles (mem_ready immediate): R-type, I-type and sw take 4; lw takes 5; beq, bne and j take 3. Each cycle mem_ready stays low adds one cycle to a memory state.
- A memory request (mem_read or mem_write) stays asserted, with address select stable, until mem_ready=1. mem_ready outside memory states is ignored.

Optional Feature:
- Macro: MC_PERF_CNT_EN.
- When defined, adds output cycle_cnt[31:0] and output instr_cnt[31:0].
  - cycle_cnt increments every non-reset cycle.
  - instr_cnt increments on instr_done.
  - Both clear on rst and wrap modulo 2^32.
- When undefined, neither port nor logic exists.

Test Plan:
- rst held 3 cycles, then released with mem_ready=1 -> all strobes 0 during reset; mem_read=1 with iord=0 in the first cycle after release.
- add (opcode 000000), mem_ready=1 -> states FETCH, DECODE, REXEC, RWB; ALUOp=0000 in REXEC; reg_write=1 and reg_dst=1 in cycle 4; instr_done pulse in cycle 4.
- lw with mem_ready low for 2 cycles in S_MEMRD -> mem_read and iord held; retires in cycle 7 with mem_to_reg=1 and reg_write=1.
- beq with zero=1, then bne with zero=1 -> pc_write=1 in S_BRANCH for beq; pc_write=0 for bne; ALUOp 0100 and 0101 respectively.
- ori (001101) -> S_IEXEC with ALUOp=1101 and imm_zext=1; slti -> ALUOp=1010 and imm_zext=0.
- Opcode 111111 with TRAP_ON_ILLEGAL=1 -> illegal=1 and no strobes until rst. rst asserted mid-S_MEMWR -> mem_write=0 in the reset cycle, state returns to S_FETCH.

Source files
------------

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multicycle main control FSM for the MIPS-subset core (optional MC_PERF_CNT_EN adds cycle/instruction counters)
module mc_ctrl #(
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_source,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       imm_zext,
    output logic [3:0] ALUOp,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       instr_done,
    output logic       illegal
`ifdef MC_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
`endif
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_RTYP = 4'b0000;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_REXEC, S_RWB, S_IEXEC, S_IWB, S_BRANCH, S_JUMP, S_TRAP
    } state_t;

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;

    logic is_mem, is_r, is_itype, is_branch, is_j;

    // Opcode classification used by the decode-state dispatch
    always_comb begin
        is_mem    = (opcode == OP_LW) || (opcode == OP_SW);
        is_r      = (opcode == OP_RTYPE);
        is_itype  = (opcode == OP_ADDI) || (opcode == OP_SLTI) || (opcode == OP_SLTIU) ||
                    (opcode == OP_ANDI) || (opcode == OP_ORI)  || (opcode == OP_XORI);
        is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
        is_j      = (opcode == OP_J);
    end

    // State register and sticky illegal flag, synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state and Moore output decode; rst forces every output to its idle value
    always_comb begin
        state_d    = state_q;
        illegal_d  = illegal_q;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_source  = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        imm_zext   = 1'b0;
        ALUOp      = ALU_ADD;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        if (!rst) begin
            illegal = illegal_q;
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_DECODE;
                    end
                end
                S_DECODE: begin
                    // ALUOut captures PC + (imm << 2) for a possible branch
                    alu_src_b = 2'b11;
                    if (is_mem) begin
                        state_d = S_MEMADR;
                    end else if (is_r) begin
                        state_d = S_REXEC;
                    end else if (is_itype) begin
                        state_d = S_IEXEC;
                    end else if (is_branch) begin
                        state_d = S_BRANCH;
                    end else if (is_j) begin
                        state_d = S_JUMP;
                    end else begin
                        illegal_d = 1'b1;
                        if (TRAP_ON_ILLEGAL) begin
                            state_d = S_TRAP;
                        end else begin
                            instr_done = 1'b1;
                            state_d    = S_FETCH;
                        end
                    end
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                    if (mem_ready) begin
                        state_d = S_MEMWB;
                    end
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                S_MEMWR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                    if (mem_ready) begin
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                end
                S_REXEC: begin
                    alu_src_a = 1'b1;
                    ALUOp     = ALU_RTYP;
                    state_d   = S_RWB;
                end
                S_RWB: begin
                    reg_write  = 1'b1;
                    reg_dst    = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                S_IEXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    ALUOp     = opcode[3:0];
                    imm_zext  = (opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI);
                    state_d   = S_IWB;
                end
                S_IWB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a  = 1'b1;
                    ALUOp      = opcode[3:0];
                    pc_source  = 2'b01;
                    pc_write   = (opcode == OP_BEQ) ? zero : ~zero;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                S_JUMP: begin
                    pc_source  = 2'b10;
                    pc_write   = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                S_TRAP: begin
                    state_d = S_TRAP;
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt_q, instr_cnt_q;

    // Free-running cycle and retired-instruction counters, wrapping modulo 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt_q <= 32'd0;
            instr_cnt_q <= 32'd0;
        end else begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
            if (instr_done) begin
                instr_cnt_q <= instr_cnt_q + 32'd1;
            end
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - self-checking bench for mc_ctrl: directed instruction table, corner sequences, random program
module tb_mc_ctrl;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       imm_zext;
        logic [3:0] aluop;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       instr_done;
        logic       illegal;
    } out_t;

    typedef struct {
        logic [5:0] op;
        logic       mr;
        logic       z;
        out_t       exp;
        string      nm;
    } cyc_t;

    typedef struct {
        logic [5:0] op;
        logic       z;
        int         sf;
        int         sm;
        int         lat;
        string      nm;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_read, mem_write, iord, ir_write, pc_write;
    logic [1:0] pc_source, alu_src_b;
    logic       alu_src_a, imm_zext;
    logic [3:0] ALUOp;
    logic       reg_write, reg_dst, mem_to_reg, instr_done, illegal;
`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    int total = 0;
    int bad   = 0;
    cyc_t q[$];

    mc_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .pc_source(pc_source), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .imm_zext(imm_zext), .ALUOp(ALUOp), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .instr_done(instr_done), .illegal(illegal)
`ifdef MC_PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic out_t base();
        out_t e;
        e = '0;
        e.aluop = 4'b0010;
        return e;
    endfunction

    function automatic out_t actual();
        out_t a;
        a.mem_read = mem_read;   a.mem_write = mem_write; a.iord = iord;
        a.ir_write = ir_write;   a.pc_write = pc_write;   a.pc_source = pc_source;
        a.alu_src_a = alu_src_a; a.alu_src_b = alu_src_b; a.imm_zext = imm_zext;
        a.aluop = ALUOp;         a.reg_write = reg_write; a.reg_dst = reg_dst;
        a.mem_to_reg = mem_to_reg; a.instr_done = instr_done; a.illegal = illegal;
        return a;
    endfunction

    task automatic check(input out_t exp, input string nm);
        out_t a;
        a = actual();
        total++;
        if (a !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, a, exp);
        end
    endtask

    function automatic void push(input logic [5:0] op, input logic mr, input logic z,
                                 input out_t e, input string nm);
        cyc_t c;
        c.op = op; c.mr = mr; c.z = z; c.exp = e; c.nm = nm;
        q.push_back(c);
    endfunction

    // Reference: the per-cycle output script of one instruction, written from the opcode map
    task automatic build(input logic [5:0] op, input int sf, input int sm, input logic z);
        out_t e;
        bit   is_i;
        is_i = (op == 6'b001000) || (op == 6'b001010) || (op == 6'b001011) ||
               (op == 6'b001100) || (op == 6'b001101) || (op == 6'b001110);
        for (int i = 0; i < sf; i++) begin
            e = base(); e.mem_read = 1; e.alu_src_b = 2'b01;
            push(op, 1'b0, 1'($urandom), e, "fetch_wait");
        end
        e = base(); e.mem_read = 1; e.alu_src_b = 2'b01; e.ir_write = 1; e.pc_write = 1;
        push(op, 1'b1, 1'($urandom), e, "fetch");
        e = base(); e.alu_src_b = 2'b11;
        push(op, 1'($urandom), 1'($urandom), e, "decode");
        if (op == 6'b100011 || op == 6'b101011) begin
            e = base(); e.alu_src_a = 1; e.alu_src_b = 2'b10;
            push(op, 1'($urandom), 1'($urandom), e, "memadr");
            e = base(); e.iord = 1;
            if (op == 6'b100011) e.mem_read = 1; else e.mem_write = 1;
            for (int i = 0; i < sm; i++) push(op, 1'b0, 1'($urandom), e, "mem_wait");
            if (op == 6'b101011) e.instr_done = 1;
            push(op, 1'b1, 1'($urandom), e, "mem_done");
            if (op == 6'b100011) begin
                e = base(); e.reg_write = 1; e.mem_to_reg = 1; e.instr_done = 1;
                push(op, 1'($urandom), 1'($urandom), e, "memwb");
            end
        end else if (op == 6'b000000) begin
            e = base(); e.alu_src_a = 1; e.aluop = 4'b0000;
            push(op, 1'($urandom), 1'($urandom), e, "rexec");
            e = base(); e.reg_write = 1; e.reg_dst = 1; e.instr_done = 1;
            push(op, 1'($urandom), 1'($urandom), e, "rwb");
        end else if (is_i) begin
            e = base(); e.alu_src_a = 1; e.alu_src_b = 2'b10; e.aluop = op[3:0];
            e.imm_zext = (op == 6'b001100) || (op == 6'b001101) || (op == 6'b001110);
            push(op, 1'($urandom), 1'($urandom), e, "iexec");
            e = base(); e.reg_write = 1; e.instr_done = 1;
            push(op, 1'($urandom), 1'($urandom), e, "iwb");
        end else if (op == 6'b000100 || op == 6'b000101) begin
            e = base(); e.alu_src_a = 1; e.aluop = op[3:0]; e.pc_source = 2'b01;
            e.pc_write = (op == 6'b000100) ? z : !z; e.instr_done = 1;
            push(op, 1'($urandom), z, e, "branch");
        end else if (op == 6'b000010) begin
            e = base(); e.pc_source = 2'b10; e.pc_write = 1; e.instr_done = 1;
            push(op, 1'($urandom), 1'($urandom), e, "jump");
        end else begin
            e = base(); e.illegal = 1;
            for (int i = 0; i < 4; i++) push(op, 1'($urandom), 1'($urandom), e, "trap");
        end
    endtask

    // Apply up to n queued cycles; returns the cycle index (1-based) of the first instr_done
    task automatic apply_n(input int n, output int lat);
        cyc_t c;
        lat = 0;
        for (int i = 0; i < n && q.size() > 0; i++) begin
            c = q.pop_front();
            @(negedge clk);
            rst = 1'b0; opcode = c.op; zero = c.z; mem_ready = c.mr;
            #1;
            if (instr_done === 1'b1 && lat == 0) lat = i + 1;
            check(c.exp, c.nm);
        end
    endtask

    task automatic reset_cycle(input string nm);
        @(negedge clk);
        rst = 1'b1; mem_ready = 1'b1; zero = 1'($urandom);
        #1;
        check(base(), nm);
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        q.delete();
        build(v.op, v.sf, v.sm, v.z);
        apply_n(q.size(), lat);
        total++;
        if (lat != v.lat) begin
            bad++;
            $display("FAIL latency_%s: got %0d want %0d", v.nm, lat, v.lat);
        end
    endtask

    initial begin
        vec_t vecs[16];
        vec_t v;
        int   lat;
        logic [5:0] legal[12];

        vecs[0]  = '{6'b000000, 1'b0, 0, 0, 4, "add"};
        vecs[1]  = '{6'b100011, 1'b0, 0, 2, 7, "lw_stall2"};
        vecs[2]  = '{6'b000100, 1'b1, 0, 0, 3, "beq_z1"};
        vecs[3]  = '{6'b000101, 1'b1, 0, 0, 3, "bne_z1"};
        vecs[4]  = '{6'b001101, 1'b0, 0, 0, 4, "ori"};
        vecs[5]  = '{6'b001010, 1'b0, 0, 0, 4, "slti"};
        vecs[6]  = '{6'b101011, 1'b0, 0, 0, 4, "sw"};
        vecs[7]  = '{6'b000010, 1'b0, 0, 0, 3, "j"};
        vecs[8]  = '{6'b100011, 1'b0, 0, 0, 5, "lw"};
        vecs[9]  = '{6'b101011, 1'b0, 1, 1, 6, "sw_stalls"};
        vecs[10] = '{6'b000101, 1'b0, 0, 0, 3, "bne_z0"};
        vecs[11] = '{6'b000100, 1'b0, 2, 0, 5, "beq_z0_fstall"};
        vecs[12] = '{6'b001000, 1'b0, 0, 0, 4, "addi"};
        vecs[13] = '{6'b001011, 1'b0, 0, 0, 4, "sltiu"};
        vecs[14] = '{6'b001100, 1'b0, 0, 0, 4, "andi"};
        vecs[15] = '{6'b001110, 1'b0, 0, 0, 4, "xori"};

        legal = '{6'b000000, 6'b000010, 6'b000100, 6'b000101, 6'b001000, 6'b001010,
                  6'b001011, 6'b001100, 6'b001101, 6'b001110, 6'b100011, 6'b101011};

        // Reset held three cycles with mem_ready high: everything idle
        for (int i = 0; i < 3; i++) reset_cycle("reset_idle");

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset in the middle of a stalled store: mem_write must drop in the reset cycle
        q.delete();
        build(6'b101011, 0, 3, 1'b0);
        apply_n(4, lat);
        q.delete();
        reset_cycle("reset_mid_memwr");
        v = '{6'b000000, 1'b0, 1, 0, 5, "add_after_reset"};
        run_vec(v);

        // Illegal opcode traps, ignores mem_ready, and only reset leaves the trap
        q.delete();
        build(6'b111111, 0, 0, 1'b0);
        apply_n(q.size(), lat);
        total++;
        if (lat != 0) begin
            bad++;
            $display("FAIL trap_no_retire: got %0d want 0", lat);
        end
        reset_cycle("reset_from_trap");
        v = '{6'b000100, 1'b1, 0, 0, 3, "beq_after_trap"};
        run_vec(v);

        // Random legal program with random stalls and flag noise
        for (int n = 0; n < 60; n++) begin
            logic [5:0] op;
            int         sf, sm, exp_lat;
            op = legal[$urandom_range(0, 11)];
            sf = $urandom_range(0, 2);
            sm = $urandom_range(0, 3);
            if (op == 6'b100011)      exp_lat = 5 + sf + sm;
            else if (op == 6'b101011) exp_lat = 4 + sf + sm;
            else if (op == 6'b000000 || op[5:3] == 3'b001) exp_lat = 4 + sf;
            else                      exp_lat = 3 + sf;
            v = '{op, 1'($urandom), sf, sm, exp_lat, "random"};
            run_vec(v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
